// File: rtl/trace_lockstep_checker.sv
// trace_lockstep_checker: lockstep compare of two DUT output buses with first-divergence capture,
// saturating mismatch count and a MISR signature of the reference stream.
module trace_lockstep_checker #(
  parameter int          OUT_W  = 159,
  parameter int          CYC_W  = 32,
  parameter int          SETTLE = 2,
  parameter int          MCNT_W = 16,
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CYC_W-1:0]  num_cycles,
  input  logic              sample_valid,
  input  logic [OUT_W-1:0]  out_a,
  input  logic [OUT_W-1:0]  out_b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              mismatch,
  output logic [CYC_W-1:0]  first_mis_cyc,
  output logic [OUT_W-1:0]  first_mis_diff,
  output logic [MCNT_W-1:0] mis_count,
  output logic [31:0]       signature
);
  typedef enum logic [1:0] {IDLE, SKIP, RUN, DONE} state_t;
  localparam int NCH = (OUT_W + 31) / 32;
  localparam int PW  = NCH * 32;
  state_t            state_q, state_d;
  logic [CYC_W-1:0]  n_q, n_d, idx_q, idx_d, fcyc_q, fcyc_d, idx_inc;
  logic [OUT_W-1:0]  fdiff_q, fdiff_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic [31:0]       sig_q, sig_d, fold;
  logic [PW-1:0]     pad;
  logic              mis_q, mis_d;
  assign idx_inc = idx_q + 1'b1;
  assign pad     = PW'(out_a);
  always_comb begin
    fold = '0;
    for (int i = 0; i < NCH; i++) fold = fold ^ pad[32*i +: 32];
  end
  // idx_q counts settle samples in SKIP and RUN sample indices in RUN
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    fcyc_d  = fcyc_q;
    fdiff_d = fdiff_q;
    mcnt_d  = mcnt_q;
    sig_d   = sig_q;
    mis_d   = 1'b0;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      n_d     = num_cycles;
      idx_d   = '0;
      fcyc_d  = '0;
      fdiff_d = '0;
      mcnt_d  = '0;
      sig_d   = SEED;
      state_d = (SETTLE > 0) ? SKIP : RUN;
    end else if (state_q == SKIP && sample_valid) begin
      idx_d   = (idx_inc == CYC_W'(SETTLE)) ? '0 : idx_inc;
      state_d = (idx_inc == CYC_W'(SETTLE)) ? RUN : SKIP;
    end else if (state_q == RUN) begin
      if (n_q == '0) begin
        state_d = DONE;
      end else if (sample_valid) begin
        idx_d = idx_inc;
        sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold;
        if (out_a != out_b) begin
          mis_d  = 1'b1;
          mcnt_d = (&mcnt_q) ? mcnt_q : mcnt_q + 1'b1;
          fcyc_d  = (mcnt_q == '0) ? idx_q : fcyc_q;
          fdiff_d = (mcnt_q == '0) ? (out_a ^ out_b) : fdiff_q;
        end
        state_d = (idx_inc == n_q) ? DONE : RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      fcyc_q  <= '0;
      fdiff_q <= '0;
      mcnt_q  <= '0;
      sig_q   <= SEED;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      fcyc_q  <= fcyc_d;
      fdiff_q <= fdiff_d;
      mcnt_q  <= mcnt_d;
      sig_q   <= sig_d;
      mis_q   <= mis_d;
    end
  end
  assign busy           = (state_q == SKIP) || (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass           = done && (mcnt_q == '0);
  assign mismatch       = mis_q;
  assign first_mis_cyc  = fcyc_q;
  assign first_mis_diff = fdiff_q;
  assign mis_count      = mcnt_q;
  assign signature      = sig_q;
endmodule
